// File: rtl/subbytes_sequencer.sv
// Byte-serial AES SubBytes / InvSubBytes / SubWord sequencer.
// One shared combinational S-box (sbox_pprm) processes the block one byte per cycle.

module sbox_pprm (
    input  logic [7:0] i_data,
    input  logic       i_encrypt,
    output logic [7:0] o_data
);

    function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gfInv(input logic [7:0] x);
        logic [7:0] x2, x3, x6, x7, x14, x15, x30, x31, x62, x63, x126, x127;
        x2   = gfMul(x, x);
        x3   = gfMul(x2, x);
        x6   = gfMul(x3, x3);
        x7   = gfMul(x6, x);
        x14  = gfMul(x7, x7);
        x15  = gfMul(x14, x);
        x30  = gfMul(x15, x15);
        x31  = gfMul(x30, x);
        x62  = gfMul(x31, x31);
        x63  = gfMul(x62, x);
        x126 = gfMul(x63, x63);
        x127 = gfMul(x126, x);
        return gfMul(x127, x127);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] x);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] invAffine(input logic [7:0] s);
        return {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    endfunction

    logic [7:0] w_pre;
    logic [7:0] w_inv;

    always_comb begin
        w_pre  = i_encrypt ? i_data : invAffine(i_data);
        w_inv  = gfInv(w_pre);
        o_data = i_encrypt ? affine(w_inv) : w_inv;
    end

endmodule

module subbytes_sequencer #(
    parameter int NBYTES    = 16,
    parameter int SBOX_PIPE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                encrypt,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*NBYTES-1:0] block_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*NBYTES-1:0] block_out,
    output logic                busy
);

    localparam int W  = 8 * NBYTES;
    localparam int CW = $clog2(NBYTES) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(NBYTES);
    localparam logic [CW-1:0] CNT_LAST = CW'(NBYTES - 1);

    generate
        if (NBYTES != 4 && NBYTES != 16) begin : g_badNbytes
            $error("subbytes_sequencer: NBYTES must be 4 or 16");
        end
        if (SBOX_PIPE != 0 && SBOX_PIPE != 1) begin : g_badPipe
            $error("subbytes_sequencer: SBOX_PIPE must be 0 or 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_nextState;
    logic [W-1:0]    r_src;
    logic [W-1:0]    r_res;
    logic [CW-1:0]   r_cnt;
    logic            r_mode;
    logic            w_accept;
    logic [7:0]      w_sboxIn;
    logic [7:0]      w_sboxOut;
    logic            w_wrEn;
    logic [CW-1:0]   w_wrIdx;
    logic [7:0]      w_wrData;
    logic            w_lastWrite;

    assign w_accept = (r_state == IDLE) && in_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (in_valid)    w_nextState = RUN;
            RUN:     if (w_lastWrite) w_nextState = DONE;
            DONE:    if (out_ready)   w_nextState = IDLE;
            default:                  w_nextState = IDLE;
        endcase
    end

    // Counter saturates at NBYTES so the pipelined variant stops issuing after the last byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_src  <= '0;
            r_mode <= 1'b1;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_src  <= block_in;
            r_mode <= encrypt;
            r_cnt  <= '0;
        end else if (r_state == RUN && r_cnt != CNT_FULL) begin
            r_cnt  <= r_cnt + CW'(1);
        end
    end

    always_comb begin
        w_sboxIn = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (r_cnt == CW'(i)) w_sboxIn = r_src[W-1-8*i -: 8];
        end
    end

    sbox_pprm u_sbox (
        .i_data    (w_sboxIn),
        .i_encrypt (r_mode),
        .o_data    (w_sboxOut)
    );

    generate
        if (SBOX_PIPE == 1) begin : g_pipe
            logic [7:0]    r_pipeData;
            logic [CW-1:0] r_pipeTag;
            logic          r_pipeValid;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_pipeData  <= '0;
                    r_pipeTag   <= '0;
                    r_pipeValid <= 1'b0;
                end else begin
                    r_pipeData  <= w_sboxOut;
                    r_pipeTag   <= r_cnt;
                    r_pipeValid <= (r_state == RUN) && (r_cnt != CNT_FULL);
                end
            end

            assign w_wrEn      = r_pipeValid && (r_state == RUN);
            assign w_wrIdx     = r_pipeTag;
            assign w_wrData    = r_pipeData;
            assign w_lastWrite = w_wrEn && (r_pipeTag == CNT_LAST);
        end else begin : g_direct
            assign w_wrEn      = (r_state == RUN);
            assign w_wrIdx     = r_cnt;
            assign w_wrData    = w_sboxOut;
            assign w_lastWrite = w_wrEn && (r_cnt == CNT_LAST);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_res <= '0;
        end else if (w_accept) begin
            r_res <= '0;
        end else if (w_wrEn) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (w_wrIdx == CW'(i)) r_res[W-1-8*i -: 8] <= w_wrData;
            end
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign block_out = r_res;

endmodule

// File: tb/tb_subbytes_sequencer.sv
// Bench for subbytes_sequencer: a 16-byte direct instance and a 4-byte pipelined instance,
// checked against an S-box table generated from the field's generator walk.

module tb_subbytes_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enc;
    logic [127:0] blk;
    logic         outRdy;
    logic         iv16, iv4;
    logic         rdy16, ov16, busy16;
    logic [127:0] bo16;
    logic         rdy4, ov4, busy4;
    logic [31:0]  bo4;

    always #5 clk = ~clk;

    subbytes_sequencer #(.NBYTES(16), .SBOX_PIPE(0)) dut16 (
        .clk(clk), .reset_n(reset_n), .encrypt(enc), .in_valid(iv16), .in_ready(rdy16),
        .block_in(blk), .out_valid(ov16), .out_ready(outRdy), .block_out(bo16), .busy(busy16)
    );

    subbytes_sequencer #(.NBYTES(4), .SBOX_PIPE(1)) dut4 (
        .clk(clk), .reset_n(reset_n), .encrypt(enc), .in_valid(iv4), .in_ready(rdy4),
        .block_in(blk[31:0]), .out_valid(ov4), .out_ready(outRdy), .block_out(bo4), .busy(busy4)
    );

    int           nChecks = 0;
    int           nPass = 0;
    logic [7:0]   sboxTab[256];
    logic [7:0]   invTab[256];
    logic [127:0] expQ[$];

    typedef struct {
        int           sel;
        logic         e;
        logic [127:0] din;
        logic [127:0] dout;
        int           lat;
    } vec_t;

    vec_t vecs[8];

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int s);
        logic [15:0] t;
        t = {v, v} << s;
        return t[15:8];
    endfunction

    // Walk p over powers of 3 while q tracks its inverse, then apply the affine map.
    task automatic buildTables();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
            sboxTab[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sboxTab[0] = 8'h63;
        for (int i = 0; i < 256; i++) invTab[sboxTab[i]] = 8'(i);
    endtask

    function automatic logic [127:0] refBlock(input logic [127:0] d, input logic e, input int nb);
        logic [127:0] r;
        logic [7:0]   b;
        r = '0;
        for (int i = 0; i < nb; i++) begin
            b = d[8*(nb-1-i) +: 8];
            r[8*(nb-1-i) +: 8] = e ? sboxTab[b] : invTab[b];
        end
        return r;
    endfunction

    function automatic logic [127:0] curOut(input int sel);
        return (sel == 0) ? bo16 : {96'd0, bo4};
    endfunction
    function automatic logic curOv(input int sel);
        return (sel == 0) ? ov16 : ov4;
    endfunction
    function automatic logic curRdy(input int sel);
        return (sel == 0) ? rdy16 : rdy4;
    endfunction
    function automatic logic curBusy(input int sel);
        return (sel == 0) ? busy16 : busy4;
    endfunction

    task automatic setIv(input int sel, input logic v);
        if (sel == 0) iv16 = v;
        else iv4 = v;
    endtask

    // Called #1 after a rising edge with the DUT idle; returns cycles from accept edge to out_valid.
    task automatic applyStimulus(input int sel, input logic [127:0] d, input logic e, output int lat);
        enc = e;
        blk = d;
        setIv(sel, 1'b1);
        @(posedge clk); #1;
        setIv(sel, 1'b0);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!curOv(sel) && lat < 64);
    endtask

    task automatic handshake();
        outRdy = 1'b1;
        @(posedge clk); #1;
        outRdy = 1'b0;
    endtask

    task automatic runRandom(input int sel, input int n, input int nb);
        int got;
        int cyc;
        fork
            begin : producer
                logic [127:0] d;
                logic         e;
                logic         r;
                logic         accepted;
                int           wd;
                for (int k = 0; k < n; k++) begin
                    d = {$urandom, $urandom, $urandom, $urandom};
                    if (nb == 4) d[127:32] = '0;
                    e = 1'($urandom % 2);
                    repeat ($urandom % 3) begin @(posedge clk); #1; end
                    enc = e;
                    blk = d;
                    setIv(sel, 1'b1);
                    accepted = 1'b0;
                    wd = 0;
                    while (!accepted && wd < 400) begin
                        r = curRdy(sel);
                        @(posedge clk); #1;
                        wd++;
                        if (r) accepted = 1'b1;
                    end
                    setIv(sel, 1'b0);
                    if (!accepted) begin
                        checkOutput($sformatf("rand%0d accept timeout", sel), 128'd0, 128'd1);
                        break;
                    end
                    expQ.push_back(refBlock(d, e, nb));
                end
            end
            begin : consumer
                got = 0;
                cyc = 0;
                while (got < n && cyc < 20000) begin
                    @(posedge clk); #1;
                    cyc++;
                    outRdy = ($urandom % 4) != 0;
                    if (curOv(sel) && outRdy) begin
                        if (expQ.size() == 0) begin
                            checkOutput($sformatf("rand%0d unexpected result", sel), curOut(sel), 128'd0);
                        end else begin
                            checkOutput($sformatf("rand%0d block %0d", sel, got), curOut(sel), expQ.pop_front());
                        end
                        got++;
                    end
                end
                @(posedge clk); #1;
                outRdy = 1'b0;
            end
        join
        checkOutput($sformatf("rand%0d result count", sel), 128'(got), 128'(n));
        checkOutput($sformatf("rand%0d leftover", sel), 128'(expQ.size()), 128'd0);
        expQ.delete();
    endtask

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int           lat;
        logic [127:0] d1, d2, d3, exp1;
        logic         stableOk;

        reset_n = 1'b0;
        enc = 1'b0;
        blk = '0;
        outRdy = 1'b0;
        iv16 = 1'b0;
        iv4 = 1'b0;
        buildTables();

        vecs[0] = '{0, 1'b1, 128'h00102030405060708090a0b0c0d0e0f0, 128'h63cab7040953d051cd60e0e7ba70e18c, 16};
        vecs[1] = '{0, 1'b0, 128'h63cab7040953d051cd60e0e7ba70e18c, 128'h00102030405060708090a0b0c0d0e0f0, 16};
        vecs[2] = '{1, 1'b1, 128'h53000063, 128'hed6363fb, 5};
        vecs[3] = '{1, 1'b0, 128'hed6363fb, 128'h53000063, 5};
        vecs[4] = '{0, 1'b1, 128'h0, {16{8'h63}}, 16};
        vecs[5] = '{0, 1'b0, 128'h0, {16{8'h52}}, 16};
        vecs[6] = '{1, 1'b1, 128'hffffffff, 128'h16161616, 5};
        vecs[7] = '{1, 1'b0, 128'h0, 128'h52525252, 5};

        #12;
        checkOutput("reset in_ready16", 128'(rdy16), 128'd1);
        checkOutput("reset out_valid16", 128'(ov16), 128'd0);
        checkOutput("reset busy16", 128'(busy16), 128'd0);
        checkOutput("reset block_out16", bo16, 128'd0);
        checkOutput("reset in_ready4", 128'(rdy4), 128'd1);
        checkOutput("reset out_valid4", 128'(ov4), 128'd0);
        checkOutput("reset block_out4", 128'(bo4), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("vec%0d ready before", i), 128'(curRdy(vecs[i].sel)), 128'd1);
            applyStimulus(vecs[i].sel, vecs[i].din, vecs[i].e, lat);
            checkOutput($sformatf("vec%0d latency", i), 128'(lat), 128'(vecs[i].lat));
            checkOutput($sformatf("vec%0d block_out", i), curOut(vecs[i].sel), vecs[i].dout);
            checkOutput($sformatf("vec%0d model", i), curOut(vecs[i].sel),
                        refBlock(vecs[i].din, vecs[i].e, vecs[i].sel == 0 ? 16 : 4));
            checkOutput($sformatf("vec%0d busy in done", i), 128'(curBusy(vecs[i].sel)), 128'd1);
            checkOutput($sformatf("vec%0d in_ready in done", i), 128'(curRdy(vecs[i].sel)), 128'd0);
            handshake();
            checkOutput($sformatf("vec%0d idle after", i), 128'({curRdy(vecs[i].sel), curOv(vecs[i].sel)}), 128'b10);
        end

        // Backpressure in DONE with input activity, then simultaneous in_valid/out_ready.
        d1 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        exp1 = refBlock(d1, 1'b1, 16);
        applyStimulus(0, d1, 1'b1, lat);
        checkOutput("bp latency", 128'(lat), 128'd16);
        stableOk = 1'b1;
        for (int c = 0; c < 10; c++) begin
            blk = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom % 2);
            iv16 = 1'($urandom % 2);
            @(posedge clk); #1;
            if (bo16 !== exp1 || rdy16 !== 1'b0 || ov16 !== 1'b1) stableOk = 1'b0;
        end
        checkOutput("bp stable block_out", bo16, exp1);
        checkOutput("bp held flags", 128'(stableOk), 128'd1);
        blk = d2;
        enc = 1'b0;
        iv16 = 1'b1;
        outRdy = 1'b1;
        @(posedge clk); #1;
        outRdy = 1'b0;
        checkOutput("bp simultaneous: output only", 128'({ov16, rdy16, busy16}), 128'b010);
        @(posedge clk); #1;
        iv16 = 1'b0;
        checkOutput("bp second accepted", 128'(busy16), 128'd1);
        lat = 0;
        while (!ov16 && lat < 64) begin @(posedge clk); #1; lat++; end
        checkOutput("bp second latency", 128'(lat), 128'd16);
        checkOutput("bp second result", bo16, refBlock(d2, 1'b0, 16));
        handshake();

        // Asynchronous reset while byte 7 is on the S-box input.
        d3 = {$urandom, $urandom, $urandom, $urandom};
        enc = 1'b1;
        blk = d3;
        iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        repeat (7) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midreset out_valid", 128'(ov16), 128'd0);
        checkOutput("midreset block_out", bo16, 128'd0);
        checkOutput("midreset in_ready", 128'(rdy16), 128'd1);
        checkOutput("midreset busy", 128'(busy16), 128'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        applyStimulus(0, d3, 1'b0, lat);
        checkOutput("postreset latency", 128'(lat), 128'd16);
        checkOutput("postreset result", bo16, refBlock(d3, 1'b0, 16));
        handshake();

        runRandom(0, 100, 16);
        runRandom(1, 30, 4);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
